// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory arbiter and future memory controllers:
// FSM state encodings and the helper that sizes requester-index fields.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Arbiter sequencing states. Encodings are fixed so that other memory
  // controllers can decode them in debug buses.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Width of an index into n requesters. It is never less than 1 so that a
  // 1-requester build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. It returns the first asserted
// request at or after ptr, wrapping from N-1 back to 0. With ptr tied to 0,
// it acts as a fixed lowest-index-wins picker.
// Ports:
//   req  in   N    request vector
//   ptr  in   IW   index that has highest priority this round
//   idx  out  IW   winning index (0 when any is low)
//   any  out  1    at least one request asserted
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  always_comb begin
    // NOTE: every combinational output gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port register-file memory (1-cycle read latency) among
// N_REQ requesters. Each grant runs one memory access, followed by a
// one-hot response pulse that carries the read data. The FSM sequence is
// IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   defined   : fixed priority, lowest asserted index wins (no RR pointer)
//   undefined : round-robin, the just-served requester drops to lowest
//               priority
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous reset, active-high
//   req_valid  in   N_REQ         request pending per requester
//   req_we     in   N_REQ         1=write, 0=read per requester
//   req_addr   in   N_REQ*ADDR_W  packed addresses
//   req_wdata  in   N_REQ*DATA_W  packed write data
//   req_ready  out  N_REQ         one-hot accept pulse
//   rsp_valid  out  N_REQ         one-hot completion pulse
//   rsp_rdata  out  DATA_W        read data during a read response, else 0
//   mem_en     out  1             memory access strobe
//   mem_we     out  1             memory write enable
//   mem_addr   out  ADDR_W        memory address
//   mem_wdata  out  DATA_W        memory write data
//   mem_rdata  in   DATA_W        memory read data (cycle after a read)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             rd_q, rd_d;        // served access was a read
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant_valid;

  assign grant_valid = req_valid[grant_q];

  // One picker serves both arbitration points (IDLE and RESP). They are
  // mutually exclusive states.
  rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q;

  // The pointer moves past the requester only when its access really happens.
  // As a result, a still-valid requester that was just served gets the lowest
  // priority at the re-arbitration in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == ST_ACCESS && grant_valid) begin
      ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    end
  end

  assign pick_ptr = ptr_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A requester that withdraws before it is accepted loses its slot.
        if (grant_valid) begin
          rd_d    = ~req_we[grant_q];
          state_d = ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Reset masks every output in the same cycle. This means an
  // access whose response would fall in the reset cycle never reports.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      unique case (state_q)
        ST_ACCESS: begin
          req_ready[grant_q] = grant_valid;
          mem_en             = grant_valid;
          mem_we             = grant_valid & req_we[grant_q];
          mem_addr           = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
          mem_wdata          = req_wdata[int'(grant_q)*DATA_W +: DATA_W];
        end
        ST_RESP: begin
          rsp_valid[grant_q] = 1'b1;
          rsp_rdata          = rd_q ? mem_rdata : '0;
        end
        default: ;
      endcase
    end
  end

endmodule
